// File: rtl/radix8_seq_multiplier.sv
// Sequential unsigned multiplier: radix-8 digits of B select precomputed multiples of A,
// accumulating one 3-bit group per cycle. Define RADIX8_MUL_ZERO_SKIP_EN for early termination.
module radix8_seq_multiplier #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iValid,
    output logic                      oReady,
    input  logic [DATA_WIDTH-1:0]     iDatA,
    input  logic [DATA_WIDTH-1:0]     iDatB,
    output logic                      oValid,
    input  logic                      iReady,
    output logic [2*DATA_WIDTH-1:0]   oProd,
    output logic [6:0]                oBoothSel
);

    localparam int NUM_GRP = (DATA_WIDTH + 2) / 3;
    localparam int BW      = 3 * NUM_GRP;
    localparam int MW      = DATA_WIDTH + 3;
    localparam int PW      = 2 * DATA_WIDTH;
    localparam int CNT_W   = $clog2(NUM_GRP + 1);

    typedef enum logic [1:0] {IDLE, PRECOMP, ACCUM, DONE} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  a_q, a_d;
    logic [BW-1:0]          b_q, b_d;
    logic [PW-1:0]          acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic [MW-1:0]          mult_q [0:7];
    logic [MW-1:0]          mult_d [0:7];
    logic [MW-1:0]          mult_calc [0:7];

    logic [2:0]             digit;
    logic [BW-1:0]          b_shift;
    logic [PW-1:0]          addend;
    logic                   last_grp;

    // Entry 0 is the constant zero multiple so a zero digit needs no special case.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mult
            assign mult_calc[gi] = MW'(gi) * {3'b000, a_q};
        end
    endgenerate

    assign digit   = b_q[2:0];
    assign b_shift = b_q >> 3;
    assign addend  = PW'(mult_q[digit]) << (3 * cnt_q);

`ifdef RADIX8_MUL_ZERO_SKIP_EN
    assign last_grp = (cnt_q == CNT_W'(NUM_GRP - 1)) || (b_shift == '0);
`else
    assign last_grp = (cnt_q == CNT_W'(NUM_GRP - 1));
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        for (int i = 0; i < 8; i++) begin
            mult_d[i] = mult_q[i];
        end
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (iValid) begin
                    a_d     = iDatA;
                    b_d     = BW'(iDatB);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = PRECOMP;
                end
            end
            PRECOMP: begin
                for (int i = 0; i < 8; i++) begin
                    mult_d[i] = mult_calc[i];
                end
                state_d = ACCUM;
            end
            ACCUM: begin
                acc_d = acc_q + addend;
                b_d   = b_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_grp) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // oValid rises one edge after entering DONE; that edge completes the latency budget.
                valid_d = 1'b1;
                if (valid_q && iReady) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                mult_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            for (int i = 0; i < 8; i++) begin
                mult_q[i] <= mult_d[i];
            end
        end
    end

    assign oReady    = (state_q == IDLE) && !iRst;
    assign oValid    = valid_q;
    assign oProd     = acc_q;
    assign oBoothSel = ((state_q == ACCUM) && (digit != 3'd0)) ? (7'd1 << (digit - 3'd1)) : 7'd0;

endmodule
